// File: rtl/if_id_reg_pkg.sv
// ---------------------------------------------------------------------------
// if_id_reg_pkg
// Shared constants for the P7 fetch/decode boundary: immediate-extension
// opcodes, the MIPS opcode/funct values the extension decode looks at, the
// fetch exception codes, and the packed layout of the IF/ID stage contents.
// ---------------------------------------------------------------------------
package if_id_reg_pkg;

    // Immediate extender operation select
    localparam logic [2:0] EXT_UNSIGNED = 3'd0;
    localparam logic [2:0] EXT_SIGNED   = 3'd1;
    localparam logic [2:0] EXT_HIGHHALF = 3'd2;
    localparam logic [2:0] EXT_SHIFTAMT = 3'd3;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_SRA = 6'h03;

    // Exception codes
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    // Contents of the IF/ID stage
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  exccode;
        logic        bd;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg_ext_op_decode.sv
// ---------------------------------------------------------------------------
// ext_op_decode
// Combinational map from an instruction word to the immediate-extension
// operation. Shared between the IF/ID register and the D-stage controller.
//
// Ports:
//   instr   in  32  instruction word
//   ext_op  out  3  EXT_UNSIGNED / EXT_SIGNED / EXT_HIGHHALF / EXT_SHIFTAMT
// ---------------------------------------------------------------------------
module ext_op_decode
    import if_id_reg_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  ext_op
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_mid;

    assign op         = instr[31:26];
    assign funct      = instr[5:0];
    // Register/immediate fields do not take part in the decode
    assign unused_mid = ^instr[25:6];

    always_comb begin
        ext_op = EXT_SIGNED;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: ext_op = EXT_UNSIGNED;
            OP_LUI:                   ext_op = EXT_HIGHHALF;
            OP_RTYPE: begin
                // Only the constant shifts carry shamt in imm16[10:6]
                if (funct == FUNCT_SLL || funct == FUNCT_SRL || funct == FUNCT_SRA)
                    ext_op = EXT_SHIFTAMT;
            end
            default:                  ext_op = EXT_SIGNED;
        endcase
    end

endmodule

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// Fetch-to-decode pipeline register of the P7 five-stage MIPS core.
// Priority at each clock edge: reset > flush > stall > load.
//
// Optional build macro: IFID_KEEP_PC_EN
//   defined   - flush keeps d_pc/d_bd so an interrupt taken on the bubble
//               still reports the right EPC and BD
//   undefined - flush clears d_pc and d_bd to zero
//
// Parameters:
//   RESET_PC   value of d_pc after reset (text-segment base)
// Ports:
//   clk        in   1   pipeline clock
//   reset      in   1   synchronous, active-high
//   f_instr    in  32   fetched instruction
//   f_pc       in  32   PC of f_instr
//   f_exccode  in   5   fetch exception code
//   f_bd       in   1   f_instr is in a branch delay slot
//   stall      in   1   hold all registers
//   flush      in   1   replace contents with a bubble
//   d_instr    out 32   registered instruction
//   d_pc       out 32   registered PC
//   d_exccode  out  5   registered exception code
//   d_bd       out  1   registered delay-slot flag
//   d_valid    out  1   stage holds a real fetched instruction
//   d_imm16    out 16   d_instr[15:0]
//   d_ext_op   out  3   extension opcode decoded from d_instr
// ---------------------------------------------------------------------------
module if_id_reg
    import if_id_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] f_instr,
    input  logic [31:0] f_pc,
    input  logic [4:0]  f_exccode,
    input  logic        f_bd,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [4:0]  d_exccode,
    output logic        d_bd,
    output logic        d_valid,
    output logic [15:0] d_imm16,
    output logic [2:0]  d_ext_op
);

    if_id_t stage_d;
    if_id_t stage_q;

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            // Bubble: instr 0 is sll $0,$0,0
            stage_d.instr   = '0;
            stage_d.exccode = EXC_NONE;
            stage_d.valid   = 1'b0;
`ifndef IFID_KEEP_PC_EN
            stage_d.pc      = '0;
            stage_d.bd      = 1'b0;
`endif
        end else if (!stall) begin
            // A faulting fetch is latched unchanged; downstream keys off exccode
            stage_d.instr   = f_instr;
            stage_d.pc      = f_pc;
            stage_d.exccode = f_exccode;
            stage_d.bd      = f_bd;
            stage_d.valid   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q.instr   <= '0;
            stage_q.pc      <= RESET_PC;
            stage_q.exccode <= EXC_NONE;
            stage_q.bd      <= 1'b0;
            stage_q.valid   <= 1'b0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign d_instr   = stage_q.instr;
    assign d_pc      = stage_q.pc;
    assign d_exccode = stage_q.exccode;
    assign d_bd      = stage_q.bd;
    assign d_valid   = stage_q.valid;
    assign d_imm16   = stage_q.instr[15:0];

    ext_op_decode u_ext_op_decode (
        .instr  (stage_q.instr),
        .ext_op (d_ext_op)
    );

endmodule

// File: doc/if_id_reg.md
# if_id_reg

Fetch-to-decode pipeline register for the P7 five-stage MIPS core. It captures the fetched instruction, its PC, the fetch-stage exception code and the delay-slot flag on each clock. It supports stall and flush. From the registered instruction it derives the 16-bit immediate and the 3-bit extension opcode, and feeds both directly to the decode-stage immediate extender. It sits between the instruction-fetch stage and the D-stage decoder/extender/register-file read.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, value loaded into d_pc on reset (text-segment base).

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- f_instr  in  32  instruction word from instruction memory.
- f_pc  in  32  PC of f_instr.
- f_exccode  in  5  fetch exception code; 0 means none, 4 means AdEL on fetch.
- f_bd  in  1  f_instr is in a branch delay slot.
- stall  in  1  hold all registers (hazard unit).
- flush  in  1  replace the contents with a bubble (exception, interrupt or eret redirect).
- d_instr  out  32  registered instruction.
- d_pc  out  32  registered PC.
- d_exccode  out  5  registered exception code.
- d_bd  out  1  registered delay-slot flag.
- d_valid  out  1  1 when the stage holds a real fetched instruction; 0 when it holds a bubble.
- d_imm16  out  16  d_instr[15:0].
- d_ext_op  out  3  extension opcode decoded from d_instr.

## Operation
- Priority on each posedge: reset > flush > stall > load.
- Reset:
  - d_instr = 0; d_pc = RESET_PC; d_exccode = 0; d_bd = 0; d_valid = 0.
- Flush:
  - d_instr = 0 (sll $0,$0,0 = nop); d_exccode = 0; d_valid = 0.
  - d_pc and d_bd follow the rule given under Configuration.
- Stall (flush = 0): every register holds its value.
- Load: d_instr = f_instr; d_pc = f_pc; d_exccode = f_exccode; d_bd = f_bd; d_valid = 1.
- When f_exccode != 0, f_instr is still latched unchanged. Downstream stages treat the instruction as a nop based on d_exccode.
- d_ext_op decode, from d_instr[31:26] (op) and d_instr[5:0] (funct):
  - op 0x0C andi, 0x0D ori, 0x0E xori → EXT_UNSIGNED.
  - op 0x0F lui → EXT_HIGHHALF.
  - op 0x00 with funct 0x00 sll, 0x02 srl, 0x03 sra → EXT_SHIFTAMT. The extender takes the shift amount from imm16[10:6].
  - Every other encoding (arithmetic immediates, slti/sltiu, loads, stores, branches, other R-type, unknown opcodes) → EXT_SIGNED.
- A bubble (d_instr = 0) decodes to EXT_SHIFTAMT with shift amount 0. This is harmless.

## Timing
- One-cycle latency: inputs sampled at edge N appear on the d_* registered outputs after edge N.
- d_imm16 and d_ext_op are purely combinational from d_instr. They add no cycle, and their path depth is a single opcode compare.
- stall and flush asserted in the same cycle: flush wins.
- flush asserted during an ongoing multi-cycle stall: a bubble is inserted at that edge. If stall stays high, the bubble is then held.
- reset asserted mid-stall or mid-flush: reset values apply at that edge.
- Outputs are stable for the whole cycle. There are no combinational paths from any input to any output.

## Configuration
- Macro IFID_KEEP_PC_EN.
  - Defined: flush keeps d_pc and d_bd at their current values. Only instr, exccode and valid are cleared. This lets an interrupt that lands on a bubble report the correct EPC and BD.
  - Undefined: flush sets d_pc = 0 and d_bd = 0.
  - Stall and reset behaviour is identical in both builds.

## Structure
- define.v (shared header) holds:
  - EXT_UNSIGNED = 3'd0, EXT_SIGNED = 3'd1, EXT_HIGHHALF = 3'd2, EXT_SHIFTAMT = 3'd3.
  - Opcode and funct constants (OP_RTYPE, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, FUNCT_SLL, FUNCT_SRL, FUNCT_SRA).
  - Exception codes EXC_ADEL = 5'd4 and EXC_NONE = 5'd0.
- One natural sub-module: ext_op_decode. It is combinational, maps d_instr[31:0] to d_ext_op[2:0], and is reused by the D-stage controller.

## Test plan
- Reset: assert reset for 2 cycles with f_pc = 0x3010 → d_pc = 0x3000, d_instr = 0, d_valid = 0, d_exccode = 0.
- Load: f_instr = 0x3C011234 (lui), f_pc = 0x3004 → next cycle d_pc = 0x3004, d_imm16 = 0x1234, d_ext_op = EXT_HIGHHALF. Then f_instr = 0x34210FF0 (ori) → d_ext_op = EXT_UNSIGNED. Then f_instr = 0x00021080 (sll) → d_ext_op = EXT_SHIFTAMT, d_imm16[10:6] = 2.
- Stall: load addiu 0x2442FFFF, then stall = 1 for 3 cycles with f_* changing → outputs frozen; d_ext_op = EXT_SIGNED throughout.
- Flush with stall: load d_pc = 0x3020 with f_bd = 1, then assert stall = 1 and flush = 1 together → d_instr = 0 and d_valid = 0. With IFID_KEEP_PC_EN, d_pc = 0x3020 and d_bd = 1; without it, d_pc = 0 and d_bd = 0.
- Fetch exception: f_exccode = 4, f_pc = 0x3001 → d_exccode = 4, d_valid = 1, d_pc = 0x3001. A following flush clears d_exccode to 0.
- Reset versus flush: assert reset and flush together mid-stall → d_pc = 0x3000 in both builds.
